// File: rtl/main_ctrl.sv
// Session timer/controller driving a mode digit and two action digits on 7-segment displays.
// Optional input debounce filter enabled by defining DEBOUNCE_EN.
module main_ctrl #(
  parameter int unsigned TICKS_PER_SEC   = 50_000_000,
  parameter int unsigned COUNTDOWN_START = 60,
  parameter int unsigned DEBOUNCE_CYC    = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_in,
  input  logic       write_mode,
  input  logic       hooked,
  input  logic       unhooked,
  output logic [6:0] out_mode,
  output logic [6:0] out1_action,
  output logic [6:0] out2_action
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EXPIRED
  } state_t;

  localparam int unsigned     PW        = $clog2(TICKS_PER_SEC + 1);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]      CD_START  = 7'(COUNTDOWN_START);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  if (TICKS_PER_SEC < 1 || DEBOUNCE_CYC < 1 || COUNTDOWN_START > 99) begin : g_bad_param
    $error("main_ctrl: invalid parameter value");
  end

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Bit order of the input vectors: {unhooked, hooked, write_mode}
  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] filt;
  logic [2:0] prev_q;
  logic [2:0] ev_q;

  assign raw = {unhooked, hooked, write_mode};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      ev_q    <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= filt;
      ev_q    <= filt & ~prev_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYC - 1);

  logic [DW-1:0] db_cnt_q [3];
  logic [2:0]    db_lvl_q;

  // Filtered level flips only after the synchronized input has differed for DEBOUNCE_CYC cycles in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      db_lvl_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_MAX) begin
          db_lvl_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign filt = db_lvl_q;
`else
  assign filt = sync2_q;
`endif

  logic ev_wm, ev_hk, ev_uh;
  assign ev_wm = ev_q[0];
  assign ev_hk = ev_q[1];
  assign ev_uh = ev_q[2];

  state_t        state_q;
  logic [1:0]    mode_q;
  logic [6:0]    counter_q;
  logic [PW-1:0] presc_q;
  logic [6:0]    out_mode_q, out1_q, out2_q;
  logic          tick;
  logic [3:0]    tens, units;

  assign tick  = (state_q == ST_ACTIVE) && (presc_q == PRESC_MAX);
  assign tens  = 4'(counter_q / 7'd10);
  assign units = 4'(counter_q % 7'd10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      counter_q  <= '0;
      presc_q    <= '0;
      out_mode_q <= 7'h40;
      out1_q     <= SEG_DASH;
      out2_q     <= SEG_DASH;
    end else begin
      // Prescaler idles at zero outside ACTIVE, so every entry starts a full second.
      if (state_q == ST_ACTIVE) presc_q <= tick ? '0 : presc_q + 1'b1;
      else                      presc_q <= '0;

      out_mode_q <= seg_digit({2'b00, mode_q});

      case (state_q)
        ST_IDLE: begin
          if (ev_wm) begin
            mode_q     <= mode_in;
            out_mode_q <= seg_digit({2'b00, mode_in});
          end
          if (!ev_uh && ev_hk && mode_q != 2'd0) begin
            if (mode_q == 2'd3) begin
              counter_q <= CD_START;
              state_q   <= (CD_START == 7'd0) ? ST_EXPIRED : ST_ACTIVE;
            end else begin
              counter_q <= '0;
              state_q   <= ST_ACTIVE;
            end
          end
        end
        ST_ACTIVE: begin
          if (ev_uh) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            case (mode_q)
              2'd1: if (counter_q != 7'd99) counter_q <= counter_q + 1'b1;
              2'd2: counter_q <= (counter_q == 7'd99) ? '0 : counter_q + 1'b1;
              2'd3: begin
                if (counter_q <= 7'd1) begin
                  counter_q <= '0;
                  state_q   <= ST_EXPIRED;
                end else begin
                  counter_q <= counter_q - 1'b1;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        ST_EXPIRED: begin
          counter_q <= '0;
          if (ev_uh) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      case (state_q)
        ST_IDLE: begin
          out1_q <= (mode_q == 2'd0) ? SEG_BLANK : SEG_DASH;
          out2_q <= (mode_q == 2'd0) ? SEG_BLANK : SEG_DASH;
        end
        ST_ACTIVE: begin
          out1_q <= seg_digit(tens);
          out2_q <= seg_digit(units);
        end
        ST_EXPIRED: begin
          out1_q <= SEG_E;
          out2_q <= SEG_E;
        end
        default: begin
          out1_q <= SEG_DASH;
          out2_q <= SEG_DASH;
        end
      endcase
    end
  end

  assign out_mode    = out_mode_q;
  assign out1_action = out1_q;
  assign out2_action = out2_q;

endmodule

// File: tb/tb_main_ctrl.sv
// Directed table-driven bench for main_ctrl with a shortened one-second tick.
module tb_main_ctrl;

  localparam int TPS = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode_in = '0;
  logic       write_mode = 1'b0;
  logic       hooked = 1'b0;
  logic       unhooked = 1'b0;
  logic [6:0] out_mode, out1_action, out2_action;

  int checks = 0;
  int errors = 0;

  main_ctrl #(
    .TICKS_PER_SEC  (TPS),
    .COUNTDOWN_START(2),
    .DEBOUNCE_CYC   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_in    (mode_in),
    .write_mode (write_mode),
    .hooked     (hooked),
    .unhooked   (unhooked),
    .out_mode   (out_mode),
    .out1_action(out1_action),
    .out2_action(out2_action)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mi;
    logic       wm;
    logic       hk;
    logic       uh;
    int         cyc;
    logic [6:0] em;
    logic [6:0] e1;
    logic [6:0] e2;
    string      name;
  } vec_t;

  vec_t tbl [16];

  task automatic apply(input logic [1:0] mi, input logic wm, input logic hk,
                       input logic uh, input int n);
    mode_in    = mi;
    write_mode = wm;
    hooked     = hk;
    unhooked   = uh;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] em,
                       input logic [6:0] e1, input logic [6:0] e2);
    checks++;
    if (out_mode !== em || out1_action !== e1 || out2_action !== e2) begin
      errors++;
      $display("FAIL %s: got %h/%h/%h expected %h/%h/%h", name,
               out_mode, out1_action, out2_action, em, e1, e2);
    end
  endtask

  initial begin
    tbl[0]  = '{2'd0, 1'b0, 1'b0, 1'b0, 3,       7'h40, 7'h7F, 7'h7F, "idle_mode0_blank"};
    tbl[1]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1,       7'h40, 7'h7F, 7'h7F, "hook_pulse_mode0"};
    tbl[2]  = '{2'd0, 1'b0, 1'b0, 1'b0, 8,       7'h40, 7'h7F, 7'h7F, "hook_mode0_ignored"};
    tbl[3]  = '{2'd1, 1'b1, 1'b0, 1'b0, 4,       7'h79, 7'h7F, 7'h7F, "mode1_load"};
    tbl[4]  = '{2'd1, 1'b1, 1'b0, 1'b0, 4,       7'h79, 7'h3F, 7'h3F, "idle_mode1_dash"};
    tbl[5]  = '{2'd1, 1'b0, 1'b0, 1'b0, 4,       7'h79, 7'h3F, 7'h3F, "wm_release"};
    tbl[6]  = '{2'd1, 1'b0, 1'b1, 1'b0, 5,       7'h79, 7'h40, 7'h40, "active_00"};
    tbl[7]  = '{2'd1, 1'b0, 1'b0, 1'b0, 5*TPS+2, 7'h79, 7'h40, 7'h12, "active_05"};
    tbl[8]  = '{2'd2, 1'b1, 1'b0, 1'b0, 4,       7'h79, 7'h40, 7'h12, "mode_frozen"};
    tbl[9]  = '{2'd0, 1'b0, 1'b0, 1'b0, 4,       7'h79, 7'h40, 7'h12, "mode_frozen_2"};
    tbl[10] = '{2'd0, 1'b0, 1'b0, 1'b1, 1,       7'h79, 7'h40, 7'h12, "unhook_pulse"};
    tbl[11] = '{2'd0, 1'b0, 1'b0, 1'b0, 4,       7'h79, 7'h3F, 7'h3F, "unhook_idle"};
    tbl[12] = '{2'd0, 1'b0, 1'b1, 1'b0, 5,       7'h79, 7'h40, 7'h40, "restart_00"};
    tbl[13] = '{2'd0, 1'b0, 1'b0, 1'b0, TPS+2,   7'h79, 7'h40, 7'h79, "restart_01"};
    tbl[14] = '{2'd0, 1'b0, 1'b0, 1'b1, 1,       7'h79, 7'h40, 7'h79, "unhook2_pulse"};
    tbl[15] = '{2'd0, 1'b0, 1'b0, 1'b0, 5,       7'h79, 7'h3F, 7'h3F, "unhook2_idle"};

    #2 reset = 1'b1;
    #1 check("reset_async", 7'h40, 7'h3F, 7'h3F);
    repeat (3) @(posedge clk);
    #1 check("reset_held", 7'h40, 7'h3F, 7'h3F);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].mi, tbl[i].wm, tbl[i].hk, tbl[i].uh, tbl[i].cyc);
      check(tbl[i].name, tbl[i].em, tbl[i].e1, tbl[i].e2);
    end

    // Mode 3 countdown from 2 to EXPIRED
    apply(2'd3, 1'b1, 1'b0, 1'b0, 5);
    apply(2'd3, 1'b0, 1'b0, 1'b0, 3);
    check("mode3_load", 7'h30, 7'h3F, 7'h3F);
    apply(2'd3, 1'b0, 1'b1, 1'b0, 5);
    check("cd_02", 7'h30, 7'h40, 7'h24);
    apply(2'd3, 1'b0, 1'b0, 1'b0, TPS+2);
    check("cd_01", 7'h30, 7'h40, 7'h79);
    apply(2'd3, 1'b0, 1'b0, 1'b0, TPS);
    check("cd_expired", 7'h30, 7'h06, 7'h06);
    apply(2'd3, 1'b0, 1'b0, 1'b0, 3*TPS);
    check("cd_expired_hold", 7'h30, 7'h06, 7'h06);
    apply(2'd3, 1'b0, 1'b1, 1'b0, 1);
    apply(2'd3, 1'b0, 1'b0, 1'b0, 2*TPS);
    check("hook_ignored_expired", 7'h30, 7'h06, 7'h06);
    apply(2'd3, 1'b0, 1'b0, 1'b1, 1);
    apply(2'd3, 1'b0, 1'b0, 1'b0, 5);
    check("cd_unhook", 7'h30, 7'h3F, 7'h3F);

    // Mode 1 saturation at 99
    apply(2'd1, 1'b1, 1'b0, 1'b0, 5);
    apply(2'd1, 1'b0, 1'b0, 1'b0, 3);
    apply(2'd1, 1'b0, 1'b1, 1'b0, 5);
    check("m1_start", 7'h79, 7'h40, 7'h40);
    apply(2'd1, 1'b0, 1'b0, 1'b0, 99*TPS+2);
    check("m1_99", 7'h79, 7'h10, 7'h10);
    apply(2'd1, 1'b0, 1'b0, 1'b0, 3*TPS);
    check("m1_saturate", 7'h79, 7'h10, 7'h10);
    apply(2'd1, 1'b0, 1'b0, 1'b1, 1);
    apply(2'd1, 1'b0, 1'b0, 1'b0, 5);
    check("m1_unhook", 7'h79, 7'h3F, 7'h3F);

    // Mode 2 wrap 99 -> 00
    apply(2'd2, 1'b1, 1'b0, 1'b0, 5);
    apply(2'd2, 1'b0, 1'b0, 1'b0, 3);
    apply(2'd2, 1'b0, 1'b1, 1'b0, 5);
    check("m2_start", 7'h24, 7'h40, 7'h40);
    apply(2'd2, 1'b0, 1'b0, 1'b0, 99*TPS+2);
    check("m2_99", 7'h24, 7'h10, 7'h10);
    apply(2'd2, 1'b0, 1'b0, 1'b0, TPS);
    check("m2_wrap_00", 7'h24, 7'h40, 7'h40);
    apply(2'd2, 1'b0, 1'b1, 1'b0, 1);
    apply(2'd2, 1'b0, 1'b0, 1'b0, TPS-1);
    check("hook_ignored_active", 7'h24, 7'h40, 7'h79);
    apply(2'd2, 1'b0, 1'b0, 1'b1, 1);
    apply(2'd2, 1'b0, 1'b0, 1'b0, 5);
    check("m2_unhook", 7'h24, 7'h3F, 7'h3F);

    // Simultaneous hooked and unhooked in IDLE
    apply(2'd2, 1'b0, 1'b1, 1'b1, 1);
    apply(2'd2, 1'b0, 1'b0, 1'b0, 6);
    check("simul_stay_idle", 7'h24, 7'h3F, 7'h3F);
    apply(2'd2, 1'b0, 1'b0, 1'b0, TPS+5);
    check("simul_no_session", 7'h24, 7'h3F, 7'h3F);

    // Asynchronous reset mid-run
    #3 reset = 1'b1;
    #1 check("reset_midrun", 7'h40, 7'h3F, 7'h3F);
    @(posedge clk);
    #1 reset = 1'b0;
    apply(2'd0, 1'b0, 1'b0, 1'b0, 3);
    check("after_reset_mode0", 7'h40, 7'h7F, 7'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
